mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM pipeline stage directly upstream of the writeback stage.
- Consumes EX/MEM results and performs load/store accesses on a variable-latency data-memory port using a req/ready handshake.
- Does byte/halfword lane steering, sign/zero extension, misalignment detection and timeout.
- Holds the MEM/WB pipeline register whose outputs feed writeback directly: MemtoReg, RegWrite, read data, ALU result, write register.

Parameters:
TIMEOUT, 16, maximum cycles spent in WAIT before the access is abandoned with bus_err (must be >= 1).

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous active-high reset
ex_valid  input  1  EX/MEM slot holds a real instruction
ex_MemRead  input  1  load
ex_MemWrite  input  1  store
ex_MemtoReg  input  1  writeback selects memory data
ex_RegWrite  input  1  instruction writes register file
ex_size  input  2  00 byte, 01 half, 10 word (11 treated as word)
ex_unsigned  input  1  zero-extend loads when 1, sign-extend when 0
ex_ALU_result  input  32  ALU result / effective address
ex_store_data  input  32  store source register value
ex_Write_reg  input  5  destination register
dmem_req  output  1  access request
dmem_we  output  1  1 store, 0 load
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables (bit i = byte lane i, little-endian)
dmem_ready  input  1  access completes in cycles where req & ready
dmem_rdata  input  32  load data, valid when req & ready & !we
mem_stall  output  1  hold EX/MEM and all earlier stages this cycle
misalign_exc  output  1  registered one-cycle exception flag
bus_err  output  1  registered one-cycle timeout flag
wb_valid  output  1  MEM/WB slot valid
wb_MemtoReg  output  1  to writeback
wb_RegWrite  output  1  to writeback
wb_Read_data  output  32  extended load data
wb_ALU_result  output  32  ALU result
wb_Write_reg  output  5  destination register

Behaviour:
- Reset: state IDLE, timeout counter 0, all registered outputs 0. dmem_req=0 and mem_stall=0 while rst high, including a reset asserted mid-WAIT; the in-flight access is dropped.
- mem_op = ex_valid & (ex_MemRead | ex_MemWrite); if both are set, treat as a store.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Never requested.
  - Next edge: misalign_exc=1, wb_valid=1, wb_RegWrite=0.
- Non-memory and invalid slots: no request, no stall. Latency 1; all wb_* copy ex_* at the next edge.
  - wb_Read_data=0.
  - wb_valid=ex_valid; wb_RegWrite=ex_RegWrite&ex_valid.
- IDLE, aligned mem_op:
  - dmem_req=1 combinationally, same cycle, driven from ex_* inputs; request fields are captured into internal registers.
  - If dmem_ready that cycle: zero-wait completion; MEM/WB loads at that edge; stay IDLE.
  - Else go to WAIT.
- WAIT:
  - dmem_req=1, and all dmem_* are driven from the captured registers, stable until the handshake.
  - On dmem_ready: complete, load MEM/WB from the captured fields, return to IDLE.
- Timeout: counter increments each WAIT cycle. When it reaches TIMEOUT with no ready:
  - Drop req, return to IDLE.
  - bus_err=1 for one cycle.
  - wb_valid=1, wb_RegWrite=0.
- mem_stall = pending & !dmem_ready & !timeout_fire, where pending = (IDLE & aligned mem_op) | WAIT.
- Whenever mem_stall=1, MEM/WB loads a bubble at that edge: wb_valid=0, wb_RegWrite=0, wb_MemtoReg=0.
- Store steering, o = addr[1:0]:
  - Byte: be = 4'b0001<<o, wdata = {4{data[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - Word: be = 1111, wdata = data.
  - Loads: be = 1111.
- Load extraction:
  - Byte: rdata[8*o+:8].
  - Half: rdata[16*addr[1]+:16].
  - Extended to 32 bits per ex_unsigned.
- Stores complete with wb_RegWrite=0 regardless of ex_RegWrite.
- misalign_exc and bus_err are each high exactly one cycle per event and are never simultaneous.

Test Plan:
- Reset, then an ADD-type slot (ex_valid=1, RegWrite=1, ALU=0x0000_1234, Write_reg=5) -> next cycle wb_valid=1, wb_RegWrite=1, wb_ALU_result=0x1234, wb_Write_reg=5, dmem_req never high.
- LB signed at addr 0x103, ready same cycle, rdata=0x80FF_0000 -> dmem_addr=0x100, be=1111, no stall, wb_Read_data=0xFFFF_FF80, wb_MemtoReg=1.
- SH at 0x202, data 0xAAAA_BEEF, ready after 3 wait cycles -> mem_stall high 3 cycles, be=1100, wdata=0xBEEF_BEEF held stable throughout, three bubbles, then wb_valid=1 with wb_RegWrite=0.
- LW at 0x301 -> no dmem_req, misalign_exc=1 for one cycle, wb_RegWrite=0.
- LW with ready never asserted, TIMEOUT=4 -> stall for 4 cycles, then req drops, bus_err pulses once, pipeline resumes.
- rst asserted during WAIT -> dmem_req and mem_stall drop immediately, all wb_* read 0, state IDLE after release.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ready data port, steers byte lanes,
// extends load data and holds the MEM/WB register that feeds writeback.
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_MemRead,
   input  logic        ex_MemWrite,
   input  logic        ex_MemtoReg,
   input  logic        ex_RegWrite,
   input  logic [1:0]  ex_size,
   input  logic        ex_unsigned,
   input  logic [31:0] ex_ALU_result,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_Write_reg,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic        misalign_exc,
   output logic        bus_err,
   output logic        wb_valid,
   output logic        wb_MemtoReg,
   output logic        wb_RegWrite,
   output logic [31:0] wb_Read_data,
   output logic [31:0] wb_ALU_result,
   output logic [4:0]  wb_Write_reg
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;

   logic          cap_we_reg;
   logic          cap_memtoreg_reg;
   logic          cap_regwrite_reg;
   logic          cap_unsigned_reg;
   logic [1:0]    cap_size_reg;
   logic [31:0]   cap_alu_reg;
   logic [31:0]   cap_wdata_reg;
   logic [3:0]    cap_be_reg;
   logic [4:0]    cap_rd_reg;

   logic          mem_op;
   logic          misaligned;
   logic          issue;
   logic          in_wait;
   logic          pending;
   logic          timeout_fire;
   logic [1:0]    ex_off;
   logic [31:0]   st_wdata;
   logic [3:0]    st_be;

   logic [1:0]    ld_size;
   logic [1:0]    ld_off;
   logic          ld_unsigned;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_data;

   assign ex_off     = ex_ALU_result[1:0];
   assign mem_op     = ex_valid & (ex_MemRead | ex_MemWrite);
   assign misaligned = ((ex_size == 2'b01) & ex_off[0]) | (ex_size[1] & (ex_off != 2'b00));
   assign issue      = mem_op & !misaligned;
   assign in_wait    = (state_reg == WAIT);
   assign pending    = in_wait | issue;

   // Last permitted WAIT cycle without ready: abandon instead of stalling again.
   assign timeout_fire = in_wait & !dmem_ready & (cnt_reg == LAST_WAIT);

   assign dmem_req  = !rst & pending;
   assign mem_stall = !rst & pending & !dmem_ready & !timeout_fire;

   // Per-lane store steering; loads enable every lane.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         always_comb begin
            st_be[gi] = 1'b1;
            if (ex_MemWrite && ex_size == 2'b00)
               st_be[gi] = (ex_off == LANE);
            else if (ex_MemWrite && ex_size == 2'b01)
               st_be[gi] = (ex_off[1] == LANE[1]);
         end
         always_comb begin
            if (ex_size == 2'b00)
               st_wdata[8*gi +: 8] = ex_store_data[7:0];
            else if (ex_size == 2'b01)
               st_wdata[8*gi +: 8] = ex_store_data[8*(gi % 2) +: 8];
            else
               st_wdata[8*gi +: 8] = ex_store_data[8*gi +: 8];
         end
      end
   endgenerate

   // While waiting, the port is driven purely from the captured request.
   assign dmem_we    = in_wait ? cap_we_reg : ex_MemWrite;
   assign dmem_addr  = in_wait ? {cap_alu_reg[31:2], 2'b00} : {ex_ALU_result[31:2], 2'b00};
   assign dmem_wdata = in_wait ? cap_wdata_reg : st_wdata;
   assign dmem_be    = in_wait ? cap_be_reg : st_be;

   assign ld_size     = in_wait ? cap_size_reg : ex_size;
   assign ld_off      = in_wait ? cap_alu_reg[1:0] : ex_off;
   assign ld_unsigned = in_wait ? cap_unsigned_reg : ex_unsigned;
   assign ld_byte     = dmem_rdata[{ld_off, 3'b000} +: 8];
   assign ld_half     = ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      if (ld_size[1])
         ld_data = dmem_rdata;
      else if (ld_size[0])
         ld_data = {{16{!ld_unsigned & ld_half[15]}}, ld_half};
      else
         ld_data = {{24{!ld_unsigned & ld_byte[7]}}, ld_byte};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= IDLE;
         cnt_reg          <= '0;
         cap_we_reg       <= 1'b0;
         cap_memtoreg_reg <= 1'b0;
         cap_regwrite_reg <= 1'b0;
         cap_unsigned_reg <= 1'b0;
         cap_size_reg     <= '0;
         cap_alu_reg      <= '0;
         cap_wdata_reg    <= '0;
         cap_be_reg       <= '0;
         cap_rd_reg       <= '0;
         misalign_exc     <= 1'b0;
         bus_err          <= 1'b0;
         wb_valid         <= 1'b0;
         wb_MemtoReg      <= 1'b0;
         wb_RegWrite      <= 1'b0;
         wb_Read_data     <= '0;
         wb_ALU_result    <= '0;
         wb_Write_reg     <= '0;
      end else begin
         // Pulses and bubble by default; overridden below when a slot retires.
         misalign_exc  <= 1'b0;
         bus_err       <= 1'b0;
         wb_valid      <= 1'b0;
         wb_MemtoReg   <= 1'b0;
         wb_RegWrite   <= 1'b0;
         wb_Read_data  <= '0;
         wb_ALU_result <= '0;
         wb_Write_reg  <= '0;

         if (state_reg == IDLE) begin
            cnt_reg          <= '0;
            cap_we_reg       <= ex_MemWrite;
            cap_memtoreg_reg <= ex_MemtoReg;
            cap_regwrite_reg <= ex_RegWrite;
            cap_unsigned_reg <= ex_unsigned;
            cap_size_reg     <= ex_size;
            cap_alu_reg      <= ex_ALU_result;
            cap_wdata_reg    <= st_wdata;
            cap_be_reg       <= st_be;
            cap_rd_reg       <= ex_Write_reg;

            if (issue && !dmem_ready) begin
               state_reg <= WAIT;
            end else if (issue) begin
               wb_valid      <= 1'b1;
               wb_MemtoReg   <= ex_MemtoReg;
               wb_RegWrite   <= ex_RegWrite & !ex_MemWrite;
               wb_Read_data  <= ex_MemWrite ? 32'h0 : ld_data;
               wb_ALU_result <= ex_ALU_result;
               wb_Write_reg  <= ex_Write_reg;
            end else begin
               // Non-memory, invalid, or misaligned slot (mem_op here means misaligned).
               wb_valid      <= ex_valid;
               wb_MemtoReg   <= ex_MemtoReg;
               wb_RegWrite   <= ex_valid & ex_RegWrite & !mem_op;
               wb_ALU_result <= ex_ALU_result;
               wb_Write_reg  <= ex_Write_reg;
               misalign_exc  <= mem_op;
            end
         end else begin
            if (dmem_ready) begin
               state_reg     <= IDLE;
               cnt_reg       <= '0;
               wb_valid      <= 1'b1;
               wb_MemtoReg   <= cap_memtoreg_reg;
               wb_RegWrite   <= cap_regwrite_reg & !cap_we_reg;
               wb_Read_data  <= cap_we_reg ? 32'h0 : ld_data;
               wb_ALU_result <= cap_alu_reg;
               wb_Write_reg  <= cap_rd_reg;
            end else if (timeout_fire) begin
               state_reg     <= IDLE;
               cnt_reg       <= '0;
               bus_err       <= 1'b1;
               wb_valid      <= 1'b1;
               wb_MemtoReg   <= cap_memtoreg_reg;
               wb_ALU_result <= cap_alu_reg;
               wb_Write_reg  <= cap_rd_reg;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   end

endmodule
